// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud strobe generation, receiver arming, FWFT byte FIFO,
// overrun and idle-line timeout reporting for the uart_rx receiver.
module uart_rx_ctrl #(
  parameter int DIV_WIDTH     = 16,
  parameter int DEPTH         = 8,
  parameter int ADDR_W        = 3,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 baud_tick,
  output logic                 rx_reset,
  input  logic                 rx_done,
  input  logic [7:0]           reg_rx,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic [ADDR_W:0]      count,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 timeout
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] L_TO = TW'(TIMEOUT_TICKS);
  localparam logic [ADDR_W:0] L_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_OFF,
    S_ARM,
    S_RUN
  } state_t;

  state_t               r_state;
  logic                 r_arm_cnt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_cnt;

  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_wr;
  logic [ADDR_W-1:0]    r_rd;
  logic [ADDR_W:0]      r_count;
  logic                 r_done_d;
  logic [TW-1:0]        r_to_cnt;

  logic w_run;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;
  logic w_to_clr;
  logic w_to_inc;

  assign w_run  = (r_state == S_RUN);
  // A byte finishing on the cycle we drop out of RUN is not captured.
  assign w_push = rx_done & ~r_done_d & w_run & enable;
  assign w_full = (r_count == L_FULL);
  assign w_pop  = rd_en & rd_valid;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  assign rd_valid = (r_count != '0);
  assign full     = w_full;
  assign count    = r_count;
  assign rd_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_OFF;
      r_arm_cnt <= 1'b0;
      r_div_q   <= '0;
      r_cnt     <= '0;
      rx_reset  <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      baud_tick <= 1'b0;
      case (r_state)
        S_OFF: begin
          r_cnt    <= '0;
          rx_reset <= 1'b0;
          if (enable) begin
            r_state   <= S_ARM;
            r_arm_cnt <= 1'b0;
            r_div_q   <= baud_div;
          end
        end
        S_ARM: begin
          if (!enable) begin
            r_state <= S_OFF;
          end else if (r_arm_cnt) begin
            r_state  <= S_RUN;
            rx_reset <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_arm_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state  <= S_OFF;
            rx_reset <= 1'b0;
            r_cnt    <= '0;
          end else if (r_cnt == r_div_q) begin
            r_cnt     <= '0;
            baud_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_OFF;
          rx_reset <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= reg_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_done_d <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      r_done_d <= rx_done;
      if (w_wr) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign w_to_clr = w_push | w_pop | ~w_run | ~rd_valid;
  assign w_to_inc = baud_tick & ~w_to_clr & (r_to_cnt != L_TO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      // Flag persists past leaving RUN until the host or receiver acts.
      if (w_push | w_pop) begin
        timeout <= 1'b0;
      end else if (w_to_inc && (r_to_cnt == L_TO - 1'b1)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed tables and sequences plus random
// traffic, all compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic        rxd = 1'b0;
  logic [7:0]  rxb = '0;
  logic        rde = 1'b0;
  logic        clr = 1'b0;

  logic        baud_tick;
  logic        rx_reset;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        full;
  logic [3:0]  count;
  logic        overrun;
  logic        timeout;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: edges with enable held high, latched divisor,
  // byte queue, sticky flags and strobes seen while data sits unread.
  int          m_on = 0;
  logic [15:0] m_div = '0;
  logic [7:0]  mq[$];
  logic        m_ovr = 1'b0;
  int          m_tcnt = 0;
  logic        m_to = 1'b0;
  logic        m_prev = 1'b0;

  uart_rx_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (en),
    .baud_div   (div),
    .baud_tick  (baud_tick),
    .rx_reset   (rx_reset),
    .rx_done    (rxd),
    .reg_rx     (rxb),
    .rd_en      (rde),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .clr_overrun(clr),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic m_tick(input int on);
    return (on > 3) && (((on - 3) % (int'(m_div) + 1)) == 0);
  endfunction

  task automatic model_step();
    int   on_pre;
    int   sz;
    logic tk;
    logic push;
    logic pop;
    on_pre = m_on;
    sz = mq.size();
    tk = m_tick(on_pre);
    if (!rst_n) begin
      m_on = 0;
      m_div = '0;
      mq.delete();
      m_ovr = 1'b0;
      m_tcnt = 0;
      m_to = 1'b0;
      m_prev = 1'b0;
    end else begin
      pop = rde && (sz > 0);
      push = rxd && !m_prev && (on_pre >= 3) && en;
      if (push && sz == 8 && !pop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push && (sz < 8 || pop)) mq.push_back(rxb);
      if (push || pop || on_pre < 3 || sz == 0) begin
        m_tcnt = 0;
      end else if (tk && m_tcnt < 64) begin
        m_tcnt++;
        if (m_tcnt == 64) m_to = 1'b1;
      end
      if (push || pop) m_to = 1'b0;
      if (en && on_pre == 0) m_div = div;
      m_on = en ? m_on + 1 : 0;
      m_prev = rxd;
    end
  endtask

  task automatic model_check();
    chk("m_tick", baud_tick, m_tick(m_on));
    chk("m_rx_reset", rx_reset, m_on >= 3);
    chk("m_valid", rd_valid, mq.size() > 0);
    chk("m_count", count, mq.size());
    chk("m_full", full, mq.size() == 8);
    chk("m_overrun", overrun, m_ovr);
    chk("m_timeout", timeout, m_to);
    if (mq.size() > 0) chk("m_data", rd_data, mq[0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    rxd = 1'b0;
    rde = 1'b0;
    clr = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       done;
    logic [7:0] byt;
    logic       rd;
    logic       valid;
    logic [7:0] data;
    logic [3:0] cnt;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] exp3[8];

  initial begin
    tbl[0]  = '{1'b1, 8'hC2, 1'b0, 1'b1, 8'hC2, 4'd1};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hC2, 4'd1};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hC2, 4'd1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, 4'd1};
    tbl[4]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'hC2, 4'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, 4'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 4'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0};
    exp3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hAA};

    // Reset state
    do_reset();
    cyc();
    chk("rst_tick", baud_tick, 1'b0);
    chk("rst_rx_reset", rx_reset, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_timeout", timeout, 1'b0);

    // Strobe timing, divisor change ignored mid-RUN
    div = 16'd3;
    en = 1'b1;
    cyc();
    chk("arm1_rx_reset", rx_reset, 1'b0);
    cyc();
    chk("arm2_rx_reset", rx_reset, 1'b0);
    cyc();
    chk("run_rx_reset", rx_reset, 1'b1);
    chk("run_tick0", baud_tick, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 6) div = 16'd9;
      cyc();
      chk("strobe", baud_tick, (k % 4) == 0);
    end

    // Capture and read table
    for (int i = 0; i < 11; i++) begin
      rxd = tbl[i].done;
      rxb = tbl[i].byt;
      rde = tbl[i].rd;
      cyc();
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_valid", rd_valid, tbl[i].valid);
      if (tbl[i].valid) chk("tbl_data", rd_data, tbl[i].data);
    end
    rxd = 1'b0;
    rde = 1'b0;

    // Full and overrun
    for (int i = 0; i < 9; i++) begin
      rxb = 8'(i);
      rxd = 1'b1;
      cyc();
      rxd = 1'b0;
      cyc();
    end
    chk("ovr_full", full, 1'b1);
    chk("ovr_count", count, 4'd8);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_head", rd_data, 8'h00);
    rxb = 8'hAA;
    rxd = 1'b1;
    rde = 1'b1;
    cyc();
    rxd = 1'b0;
    rde = 1'b0;
    chk("pp_count", count, 4'd8);
    chk("pp_overrun", overrun, 1'b1);
    chk("pp_head", rd_data, 8'h01);
    cyc();
    rxb = 8'hBB;
    rxd = 1'b1;
    clr = 1'b1;
    cyc();
    rxd = 1'b0;
    clr = 1'b0;
    chk("clr_vs_new", overrun, 1'b1);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_only", overrun, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", rd_data, exp3[i]);
      rde = 1'b1;
      cyc();
      rde = 1'b0;
    end
    chk("drain_empty", rd_valid, 1'b0);

    // Idle-line timeout
    do_reset();
    div = 16'd0;
    en = 1'b1;
    repeat (6) cyc();
    rxb = 8'h5A;
    rxd = 1'b1;
    cyc();
    rxd = 1'b0;
    chk("to_count", count, 4'd1);
    for (int k = 1; k <= 70; k++) begin
      cyc();
      chk("to_wait", timeout, k >= 64);
    end
    rde = 1'b1;
    cyc();
    rde = 1'b0;
    chk("to_pop", timeout, 1'b0);
    for (int k = 0; k < 200; k++) begin
      cyc();
      chk("to_empty", timeout, 1'b0);
    end

    // Disable and reset mid-operation
    do_reset();
    div = 16'd3;
    en = 1'b1;
    repeat (5) cyc();
    for (int i = 0; i < 3; i++) begin
      rxb = 8'hA1 + 8'(i);
      rxd = 1'b1;
      cyc();
      rxd = 1'b0;
      cyc();
    end
    en = 1'b0;
    rxb = 8'hEE;
    rxd = 1'b1;
    cyc();
    rxd = 1'b0;
    chk("dis_rx_reset", rx_reset, 1'b0);
    chk("dis_tick", baud_tick, 1'b0);
    chk("dis_count", count, 4'd3);
    chk("dis_head", rd_data, 8'hA1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("off_tick", baud_tick, 1'b0);
    end
    rxd = 1'b1;
    cyc();
    rxd = 1'b0;
    chk("off_nocap", count, 4'd3);
    rde = 1'b1;
    cyc();
    rde = 1'b0;
    chk("off_pop_cnt", count, 4'd2);
    chk("off_pop_data", rd_data, 8'hA2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mrst_count", count, 4'd0);
    chk("mrst_valid", rd_valid, 1'b0);
    chk("mrst_overrun", overrun, 1'b0);
    chk("mrst_rx_reset", rx_reset, 1'b0);
    chk("mrst_tick", baud_tick, 1'b0);
    cyc();
    chk("mrst_off", rx_reset, 1'b0);

    // Random traffic; quiet windows let the timeout fire
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      automatic logic busy = ((c / 400) % 2) == 1;
      if (en) begin
        if ($urandom_range(999) < 2) en = 1'b0;
      end else if ($urandom_range(99) < 10) begin
        en = 1'b1;
      end
      if ($urandom_range(99) < 3) div = 16'($urandom_range(busy ? 3 : 1));
      if ($urandom_range(99) < (busy ? 15 : 1)) rxd = ~rxd;
      rxb = 8'($urandom);
      rde = busy && ($urandom_range(99) < 35);
      clr = $urandom_range(99) < 4;
      rst_n = $urandom_range(1999) != 0;
      cyc();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the uart_rx receiver.
- Generates the 16x-oversample baud strobe from a programmable divisor.
- Owns the receiver's reset/arming sequence.
- Captures each completed byte into a small first-word-fall-through FIFO and presents it to the host over a read handshake.
- Reports overrun and an idle-line timeout.

Parameters:
DIV_WIDTH, 16, width of baud divisor
DEPTH, 8, FIFO entries (power of 2, >=2)
ADDR_W, 3, log2(DEPTH)
TIMEOUT_TICKS, 64, baud strobes of silence (non-empty FIFO) before timeout asserts

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
enable  in  1  1 = run receiver, 0 = hold receiver off
baud_div  in  DIV_WIDTH  strobe period minus 1, in clk cycles
baud_tick  out  1  one-clk strobe, drives receiver baud_rate_clk enable
rx_reset  out  1  receiver reset, active-low; receiver held off while 0
rx_done  in  1  receiver byte-complete (level, may last >1 clk)
reg_rx  in  8  received byte, valid when rx_done high
rd_en  in  1  host pop request
rd_data  out  8  FIFO head (FWFT)
rd_valid  out  1  FIFO non-empty
full  out  1  FIFO full
count  out  ADDR_W+1  FIFO occupancy
overrun  out  1  sticky: byte dropped because FIFO full
clr_overrun  in  1  clears overrun
timeout  out  1  idle-line timeout flag

Behaviour:
- Reset (reset=0 at posedge) clears everything:
  - Outputs: baud_tick=0, rx_reset=0, rd_valid=0, full=0, count=0, overrun=0, timeout=0; rd_data don't-care.
  - State=OFF; divisor counter=0; timeout counter=0; rx_done_d=0.
- FSM:
  - OFF: rx_reset=0, baud counter held 0, no strobes. enable=1 -> ARM.
  - ARM: lasts exactly 2 clk; rx_reset=0; div_q<=baud_div latched on entry. Then -> RUN. enable=0 during ARM -> OFF.
  - RUN: rx_reset=1, strobes active. enable=0 -> OFF next clk (rx_reset=0 that cycle).
- baud_div changes during RUN are ignored until the next OFF->ARM.
- Baud strobe (RUN only):
  - cnt increments each clk; when cnt==div_q, cnt<=0 and baud_tick=1 for the next single clk.
  - Period = div_q+1 clk; div_q=0 gives baud_tick high every clk.
  - First strobe occurs div_q+1 clk after entering RUN.
- Capture:
  - push = rx_done & ~rx_done_d & (state==RUN). Level rx_done pushes exactly once.
  - push & !full: write reg_rx at tail, count+1.
  - push & full & !pop: byte dropped, overrun<=1.
  - push & pop when full: both occur, count unchanged, no overrun.
- Read:
  - rd_data = head entry combinationally; rd_valid = count!=0.
  - pop = rd_en & rd_valid at posedge; rd_en on empty is ignored (no underflow, pointers unchanged).
  - Pointers wrap modulo DEPTH; full = count==DEPTH.
- Overrun: sticky. clr_overrun clears it; new overrun in the same cycle wins (stays 1).
- Timeout:
  - Counter increments on each baud_tick while RUN and rd_valid.
  - Counter cleared on push, pop, leaving RUN, or FIFO empty.
  - timeout<=1 when counter reaches TIMEOUT_TICKS; counter saturates there.
  - timeout cleared on push or pop. Never asserts with FIFO empty.
- Disable mid-frame (enable 1->0):
  - Receiver forced into reset and strobes stop.
  - A byte completing in the same cycle as the OFF transition is not captured.
  - FIFO contents, count and overrun are retained; host reads are still serviced in OFF/ARM.
- reset mid-operation: all state cleared as above, regardless of FSM state; FIFO contents discarded.
- Latency: rx_done rising at posedge N -> rd_valid=1 and rd_data valid after posedge N+1.

Test Plan:
- Strobe timing: baud_div=3, enable=1 -> rx_reset=0 for 2 clk, then 1; baud_tick pulses every 4 clk, first at 4 clk after RUN entry; baud_div changed to 9 mid-RUN -> period stays 4.
- Capture/read: inject rx_done held 3 clk with reg_rx=0xC2, then 0x41 -> count=2, rd_data=0xC2; rd_en 1 clk -> rd_data=0x41, count=1; rd_en again -> rd_valid=0; extra rd_en on empty -> count stays 0.
- Full/overrun: push 9 bytes 0x00..0x08 with DEPTH=8 -> full=1, overrun=1, reads return 0x00..0x07. Push+pop in the same cycle while full -> count=8, overrun unchanged. clr_overrun and a new overrun in the same cycle -> overrun=1.
- Timeout: baud_div=0, one byte pushed, no reads -> timeout=1 after 64 strobes; pop -> timeout=0; empty FIFO for 200 strobes -> timeout stays 0.
- Disable/reset mid-operation: 3 bytes queued, enable=0 -> rx_reset=0, baud_tick=0, count=3 readable. Then reset=0 for 1 clk -> count=0, overrun=0, rx_reset=0, state OFF.
